// File: rtl/keypad_pkg.sv
// Shared key codes, buffer depth and FSM state encoding for the keypad number-entry block.
package keypad_pkg;

  localparam logic [4:0] KEY_NONE    = 5'h10;
  localparam logic [4:0] KEY_BKSP    = 5'h0E;
  localparam logic [4:0] KEY_ENTER   = 5'h0F;
  localparam logic [4:0] KEY_DEC_MAX = 5'h09;
  localparam logic [4:0] KEY_HEX_MAX = 5'h0D;

  localparam int MAX_DIGITS = 8;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_CONVERT_ENC = 2'd1;
  localparam logic [1:0] ST_HOLD_ENC    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_CONVERT = ST_CONVERT_ENC,
    ST_HOLD    = ST_HOLD_ENC
  } state_t;

endpackage

// File: rtl/key_event_detect.sv
// Synchronizes the scanner code, waits for it to settle, and emits one pulse per key press.
module key_event_detect
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_key,
  output logic       o_evt,
  output logic [3:0] o_evt_code
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_CYCLES - 1);

  logic [4:0]    r_k_meta;
  logic [4:0]    r_k_s;
  logic [4:0]    r_k_s_d;
  logic [4:0]    r_k_a;
  logic [CW-1:0] r_cnt;
  logic          r_evt;
  logic [3:0]    r_evt_code;

  logic       w_chg;
  logic [4:0] w_k_norm;

  assign w_chg    = (r_k_s != r_k_s_d);
  // Anything above the no-key code is treated as a released keypad.
  assign w_k_norm = (r_k_s_d > KEY_NONE) ? KEY_NONE : r_k_s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k_meta   <= KEY_NONE;
      r_k_s      <= KEY_NONE;
      r_k_s_d    <= KEY_NONE;
      r_k_a      <= KEY_NONE;
      r_cnt      <= '0;
      r_evt      <= 1'b0;
      r_evt_code <= '0;
    end else begin
      r_k_meta <= i_key;
      r_k_s    <= r_k_meta;
      r_k_s_d  <= r_k_s;
      r_evt    <= 1'b0;
      if (w_chg) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_k_a <= w_k_norm;
        if (r_k_a == KEY_NONE && w_k_norm != KEY_NONE) begin
          r_evt      <= 1'b1;
          r_evt_code <= w_k_norm[3:0];
        end
      end
    end
  end

  assign o_evt      = r_evt;
  assign o_evt_code = r_evt_code;

endmodule

// File: rtl/keypad_num_entry.sv
// Keypad digit buffer with backspace/enter editing, BCD-to-binary converter and valid/ready commit.
// state   | meaning
// IDLE    | accepting key events, editing the digit buffer
// CONVERT | shift-add decimal conversion, one digit per cycle, MSD first
// HOLD    | value_valid high, waiting for the consumer handshake
module keypad_num_entry
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  key,
  input  logic        dec_mode,
  output logic [31:0] value,
  output logic        value_valid,
  input  logic        value_ready,
  output logic [31:0] digits,
  output logic [3:0]  digit_cnt,
  output logic        busy,
  output logic        full
);

  state_t      r_state;
  logic [31:0] r_digits;
  logic [3:0]  r_cnt;
  logic [31:0] r_acc;
  logic [2:0]  r_idx;
  logic [31:0] r_value;
  logic        r_valid;

  logic        w_evt;
  logic [3:0]  w_evt_code;
  logic [4:0]  w_code;
  logic        w_is_digit;
  logic [3:0]  w_nib;
  logic [31:0] w_acc_next;

  key_event_detect #(.STABLE_CYCLES(STABLE_CYCLES)) u_det (
    .clk        (clk),
    .rst        (rst),
    .i_key      (key),
    .o_evt      (w_evt),
    .o_evt_code (w_evt_code)
  );

  assign w_code     = {1'b0, w_evt_code};
  assign w_is_digit = (w_code <= KEY_DEC_MAX) || (!dec_mode && w_code <= KEY_HEX_MAX);
  assign w_nib      = r_digits[{r_idx, 2'b00} +: 4];
  // acc*10 as two shifts; buffered hex letters in decimal mode simply add their nibble value.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {28'd0, w_nib};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_digits <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_value  <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_evt) begin
            if (w_is_digit) begin
              if (r_cnt < 4'(MAX_DIGITS)) begin
                r_digits <= {r_digits[27:0], w_evt_code};
                r_cnt    <= r_cnt + 1'b1;
              end
            end else if (w_code == KEY_BKSP) begin
              if (r_cnt != '0) begin
                r_digits <= r_digits >> 4;
                r_cnt    <= r_cnt - 1'b1;
              end
            end else if (w_code == KEY_ENTER) begin
              if (dec_mode) begin
                r_acc   <= '0;
                r_idx   <= 3'd7;
                r_state <= ST_CONVERT;
              end else begin
                r_value <= r_digits;
                r_valid <= 1'b1;
                r_state <= ST_HOLD;
              end
            end
          end
        end
        ST_CONVERT: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx - 1'b1;
          if (r_idx == 3'd0) begin
            r_value <= w_acc_next;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (value_ready) begin
            r_valid  <= 1'b0;
            r_digits <= '0;
            r_cnt    <= '0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign value       = r_value;
  assign value_valid = r_valid;
  assign digits      = r_digits;
  assign digit_cnt   = r_cnt;
  assign busy        = (r_state != ST_IDLE);
  assign full        = (r_cnt == 4'(MAX_DIGITS));

endmodule
